// File: rtl/flash_pkg.sv
// Shared state encoding, opcodes and timing constants for the SPI flash reader.
// Defining FLASH_READER_WAKE_EN adds the release-power-down states.
package flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WAKE = 8'hAB;
  localparam int WAKE_DELAY_CYCLES = 81;

`ifdef FLASH_READER_WAKE_EN
  typedef enum logic [2:0] {
    ST_INIT_WAIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_CMD       = 3'd2,
    ST_READ      = 3'd3,
    ST_GAP       = 3'd4,
    ST_WAKE_SEND = 3'd5,
    ST_WAKE_WAIT = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_INIT_WAIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_CMD       = 3'd2,
    ST_READ      = 3'd3,
    ST_GAP       = 3'd4
  } state_e;
`endif

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/flash_reader_if.sv
// SPI bus between the flash reader (master) and the serial flash device (slave).
interface flash_reader_if;
  logic flash_clk;
  logic flash_cs_n;
  logic flash_mosi;
  logic flash_miso;

  modport master (
    output flash_clk,
    output flash_cs_n,
    output flash_mosi,
    input  flash_miso
  );

  modport slave (
    input  flash_clk,
    input  flash_cs_n,
    input  flash_mosi,
    output flash_miso
  );
endinterface

// File: rtl/flash_spi_phy.sv
// Mode-0 SPI bit engine: SCK divider, MOSI shift-out on the falling edge,
// MISO sample on the rising edge, and a bit_done strobe on every falling edge.
module flash_spi_phy #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        load_i,
  input  logic [31:0] load_word_i,
  input  logic        miso_i,
  output logic        sck_o,
  output logic        mosi_o,
  output logic        bit_done_o,
  output logic [7:0]  rx_byte_o
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic [31:0]      tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             tick, rise, fall;

  always_comb begin
    tick  = en_i && (div_q == DIV_LAST);
    rise  = tick && !sck_q;
    fall  = tick && sck_q;
    div_d = div_q;
    sck_d = sck_q;
    if (!en_i) begin
      div_d = '0;
      sck_d = 1'b0;
    end else if (tick) begin
      div_d = '0;
      sck_d = !sck_q;
    end else begin
      div_d = div_q + 1'b1;
    end
    // Zero fill means MOSI falls back to 0 once the command has been shifted out.
    tx_d = tx_q;
    if (load_i) begin
      tx_d = load_word_i;
    end else if (fall) begin
      tx_d = {tx_q[30:0], 1'b0};
    end
    rx_d = rx_q;
    if (rise) begin
      rx_d = {rx_q[6:0], miso_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      sck_q <= 1'b0;
      tx_q  <= '0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
      tx_q  <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_q <= rx_d;
  end

  assign sck_o      = sck_q;
  assign mosi_o     = tx_q[31];
  assign bit_done_o = fall;
  assign rx_byte_o  = rx_q;

endmodule

// File: rtl/flash_reader.sv
// SPI flash READ (0x03) controller delivering MEMORY_LENGTH bytes as one packed word.
// Optional FLASH_READER_WAKE_EN sends a release-power-down (0xAB) once after reset.
module flash_reader
  import flash_pkg::*;
#(
  parameter int MEMORY_LENGTH = 4,
  parameter int CLK_DIV       = 2,
  parameter int STARTUP_DELAY = 10000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [23:0]                addr,
  output logic                       busy,
  output logic                       data_ready,
  output logic [MEMORY_LENGTH*8-1:0] data_out,
  flash_reader_if.master             spi
);

  localparam int N        = 32 + 8 * MEMORY_LENGTH;
  localparam int BIT_W    = $clog2(N);
  localparam int BYTE_W   = $clog2(MEMORY_LENGTH + 1);
  localparam int WAIT_MAX = max3(STARTUP_DELAY, WAKE_DELAY_CYCLES, 2 * CLK_DIV);
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  state_e                     state_q, state_d;
  logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]          byte_cnt_q, byte_cnt_d;
  logic [WAIT_W-1:0]          wait_q, wait_d;
  logic [MEMORY_LENGTH*8-1:0] buf_q, buf_d;
  logic [MEMORY_LENGTH*8-1:0] data_out_q, data_out_d;
  logic                       data_ready_q, data_ready_d;
  logic                       cs_n_q, cs_n_d;
  logic                       load;
  logic [31:0]                load_word;
  logic                       bit_done;
  logic [7:0]                 rx_byte;
  logic                       sck, mosi;

  flash_spi_phy #(.CLK_DIV(CLK_DIV)) u_phy (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (!cs_n_q),
    .load_i     (load),
    .load_word_i(load_word),
    .miso_i     (spi.flash_miso),
    .sck_o      (sck),
    .mosi_o     (mosi),
    .bit_done_o (bit_done),
    .rx_byte_o  (rx_byte)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    wait_d       = wait_q;
    buf_d        = buf_q;
    data_out_d   = data_out_q;
    data_ready_d = 1'b0;
    load         = 1'b0;
    load_word    = '0;
    case (state_q)
      ST_INIT_WAIT: begin
        if (wait_q == WAIT_W'(STARTUP_DELAY - 1)) begin
          wait_d = '0;
`ifdef FLASH_READER_WAKE_EN
          state_d   = ST_WAKE_SEND;
          load      = 1'b1;
          load_word = {OP_WAKE, 24'h000000};
          bit_cnt_d = '0;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
`ifdef FLASH_READER_WAKE_EN
      ST_WAKE_SEND: begin
        if (bit_done) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_W'(7)) begin
            state_d = ST_WAKE_WAIT;
            wait_d  = '0;
          end
        end
      end
      ST_WAKE_WAIT: begin
        if (wait_q == WAIT_W'(WAKE_DELAY_CYCLES - 1)) state_d = ST_IDLE;
        else wait_d = wait_q + 1'b1;
      end
`endif
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CMD;
          load       = 1'b1;
          load_word  = {OP_READ, addr};
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end
      ST_CMD: begin
        if (bit_done) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_W'(31)) state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (bit_done) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          // Reads start on a 32-bit boundary, so the low three bits mark byte ends.
          if (bit_cnt_q[2:0] == 3'd7) begin
            buf_d[{byte_cnt_q, 3'b000} +: 8] = rx_byte;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
          if (bit_cnt_q == BIT_W'(N - 1)) begin
            state_d      = ST_GAP;
            data_out_d   = buf_d;
            data_ready_d = 1'b1;
            wait_d       = '0;
          end
        end
      end
      ST_GAP: begin
        if (wait_q == WAIT_W'(2 * CLK_DIV - 1)) state_d = ST_IDLE;
        else wait_d = wait_q + 1'b1;
      end
      default: state_d = ST_INIT_WAIT;
    endcase
`ifdef FLASH_READER_WAKE_EN
    cs_n_d = !((state_d == ST_CMD) || (state_d == ST_READ) || (state_d == ST_WAKE_SEND));
`else
    cs_n_d = !((state_d == ST_CMD) || (state_d == ST_READ));
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_INIT_WAIT;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      wait_q       <= '0;
      cs_n_q       <= 1'b1;
      data_ready_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      wait_q       <= wait_d;
      cs_n_q       <= cs_n_d;
      data_ready_q <= data_ready_d;
      data_out_q   <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign busy           = (state_q != ST_IDLE);
  assign data_ready     = data_ready_q;
  assign data_out       = data_out_q;
  assign spi.flash_clk  = sck;
  assign spi.flash_cs_n = cs_n_q;
  assign spi.flash_mosi = mosi;

endmodule

// File: tb/tb_flash_reader.sv
// Scoreboard bench for flash_reader with a behavioural SPI flash and timing model.
module tb_flash_reader;
  import flash_pkg::*;

  localparam int M    = 4;
  localparam int CD   = 2;
  localparam int SD   = 200;
  localparam int NB   = 32 + 8 * M;
  localparam int XFER = 2 * NB * CD;
  localparam int GAPC = 2 * CD;
`ifdef FLASH_READER_WAKE_EN
  localparam int WAKE_T = 16 * CD + 81;
`else
  localparam int WAKE_T = 0;
`endif

  typedef struct {
    logic [31:0]    cmd;
    logic [M*8-1:0] data;
    int             done;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [23:0]    addr = '0;
  logic           busy, data_ready;
  logic [M*8-1:0] data_out;

  flash_reader_if spi ();

  flash_reader #(.MEMORY_LENGTH(M), .CLK_DIV(CD), .STARTUP_DELAY(SD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .addr      (addr),
    .busy      (busy),
    .data_ready(data_ready),
    .data_out  (data_out),
    .spi       (spi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_edge = 1 << 30;
  bit armed = 1'b0;
  bit rst_edge = 1'b0;
  bit expect_wake = 1'b0;
  logic [M*8-1:0] model_dout = '0;
  exp_t exp_q[$];
  exp_t mx, px;

  int          fcnt = 0;
  logic [31:0] fcmd = '0;
  bit          sck_prev = 1'b0, cs_prev = 1'b1, mosi_prev = 1'b0;
  int          last_rise = 0, cs_hi = 0, idx = 0;
  logic [7:0]  fb;

  function automatic void chk(input bit ok, input string name, input logic [63:0] act,
                              input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000000: return 8'h48;
      24'h000001: return 8'h65;
      24'h000002: return 8'h6C;
      24'h000003: return 8'h6C;
      default:    return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [M*8-1:0] expect_block(input logic [23:0] a);
    logic [M*8-1:0] d;
    d = '0;
    for (int i = 0; i < M; i++) d[i*8 +: 8] = mem_byte(a + 24'(i));
    return d;
  endfunction

  // Monitor, flash model and timing reference; runs on the falling clock edge.
  initial begin
    spi.flash_miso = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (armed) begin
        if (rst_edge) begin
          chk(spi.flash_cs_n == 1'b1, "rst_cs_n", spi.flash_cs_n, 1);
          chk(spi.flash_clk == 1'b0, "rst_sck", spi.flash_clk, 0);
          chk(spi.flash_mosi == 1'b0, "rst_mosi", spi.flash_mosi, 0);
          chk(data_ready == 1'b0, "rst_data_ready", data_ready, 0);
          chk(data_out == '0, "rst_data_out", data_out, 0);
        end
        chk(busy == (cyc < ready_edge), "busy", busy, cyc < ready_edge);
        if (data_ready) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "spurious_data_ready", 1, 0);
          end else begin
            mx = exp_q.pop_front();
            chk(data_out == mx.data, "data_out", data_out, mx.data);
            chk(cyc == mx.done, "ready_cycle", cyc, mx.done);
            chk(fcmd == mx.cmd, "mosi_cmd", fcmd, mx.cmd);
            chk(fcnt == NB, "sck_count", fcnt, NB);
            model_dout = mx.data;
          end
        end else begin
          chk(data_out == model_dout, "data_hold", data_out, model_dout);
          if (exp_q.size() != 0 && cyc > exp_q[0].done) begin
            chk(1'b0, "missing_data_ready", 0, exp_q[0].done);
            mx = exp_q.pop_front();
            model_dout = mx.data;
          end
        end
        if (spi.flash_cs_n) begin
          chk(spi.flash_clk == 1'b0, "sck_idle", spi.flash_clk, 0);
          chk(spi.flash_mosi == 1'b0, "mosi_idle", spi.flash_mosi, 0);
        end
        if (spi.flash_mosi != mosi_prev) chk(spi.flash_clk == 1'b0, "mosi_edge", spi.flash_clk, 0);
      end

      if (spi.flash_cs_n) begin
        if (!cs_prev && fcnt == 8) begin
          chk(expect_wake, "wake_once", 1, expect_wake);
          chk(fcmd[7:0] == OP_WAKE, "wake_cmd", fcmd[7:0], OP_WAKE);
          expect_wake = 1'b0;
        end
        fcnt = 0;
        fcmd = '0;
        spi.flash_miso = 1'b0;
        cs_hi++;
      end else begin
        if (cs_prev && armed) chk(cs_hi >= GAPC, "cs_gap", cs_hi, GAPC);
        cs_hi = 0;
        if (spi.flash_clk && !sck_prev) begin
          if (fcnt > 0) chk(cyc - last_rise == 2 * CD, "sck_period", cyc - last_rise, 2 * CD);
          last_rise = cyc;
          if (fcnt < 32) fcmd = {fcmd[30:0], spi.flash_mosi};
          fcnt++;
        end else if (!spi.flash_clk && sck_prev && fcnt >= 32) begin
          idx = fcnt - 32;
          fb = mem_byte(fcmd[23:0] + 24'(idx / 8));
          spi.flash_miso = fb[7 - idx % 8];
        end
      end
      sck_prev  = spi.flash_clk;
      cs_prev   = spi.flash_cs_n;
      mosi_prev = spi.flash_mosi;

      // Predict the effect of the inputs at the coming rising edge.
      if (!rst_n) begin
        exp_q.delete();
        ready_edge  = cyc + 1 + SD + WAKE_T;
        model_dout  = '0;
        armed       = 1'b1;
        expect_wake = (WAKE_T != 0);
      end else if (armed && start && cyc >= ready_edge) begin
        px.cmd  = {OP_READ, addr};
        px.data = expect_block(addr);
        px.done = cyc + 1 + XFER;
        exp_q.push_back(px);
        ready_edge = cyc + 1 + XFER + GAPC;
      end
      rst_edge = !rst_n;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(posedge clk); #2;
    while (cyc + 1 < ready_edge && n < 20000) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 20000) chk(1'b0, "wait_ready_timeout", n, 20000);
  endtask

  task automatic issue(input logic [23:0] a);
    start = 1'b1;
    addr  = a;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    // Request while still in the power-up wait.
    repeat (50) @(posedge clk);
    #2 issue(24'h000100);

    wait_ready();
    issue(24'h000000);
    wait_ready();
    issue(24'h012345);

    // Request mid-READ.
    wait_ready();
    issue(24'h00ABCD);
    repeat (120) @(posedge clk);
    #2 issue(24'h001111);

    for (int i = 0; i < 6; i++) begin
      wait_ready();
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #2 issue(24'($urandom));
    end

    // Reset around bit 40 of the READ phase.
    wait_ready();
    issue(24'h0F0F0F);
    repeat (CD + 40 * 2 * CD - 1) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    wait_ready();
    issue(24'($urandom));

    // Start held high across several reads.
    wait_ready();
    start = 1'b1;
    for (int i = 0; i < 3 * (XFER + GAPC + 1) + 10; i++) begin
      addr = 24'($urandom);
      @(posedge clk); #2;
    end
    start = 1'b0;

    wait_ready();
    repeat (20) @(posedge clk);
    chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    chk(!expect_wake, "wake_sent", expect_wake, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/flash_reader.md
# flash_reader

SPI flash read controller for the flash console path. It issues a standard READ (0x03) command with a 24-bit address and shifts in `MEMORY_LENGTH` bytes. It presents them as one packed vector for the downstream UART transmitter's `dataToSend` input. It sits directly upstream of the UART TX: on a request it reads, latches and flags a new block.

## Interface
Parameters:
- `MEMORY_LENGTH`, default 4: bytes read per request. Range 1–15.
- `CLK_DIV`, default 2: `clk` cycles per SCK half-period. Default gives 6.75 MHz SCK at 27 MHz. Minimum 1.
- `STARTUP_DELAY`, default 10000: `clk` cycles after reset before the first request is accepted (flash tPU).

Ports:
- `clk`  in  1  system clock, 27 MHz.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `start`  in  1  read request. Level-sampled; accepted only in IDLE.
- `addr`  in  24  flash byte address. Captured on acceptance.
- `busy`  out  1  high from reset until IDLE, and from acceptance until the end of the CS gap.
- `data_ready`  out  1  one-cycle pulse when `data_out` updates.
- `data_out`  out  `MEMORY_LENGTH*8`  read data. The first byte read is in bits [7:0], the next in [15:8], and so on.
- `flash_clk`  out  1  SPI SCK, mode 0 (idle low).
- `flash_cs_n`  out  1  chip select, active low.
- `flash_mosi`  out  1  serial command/address, MSB first.
- `flash_miso`  in  1  serial data from the flash, MSB first per byte.

## Operation
States: INIT_WAIT → [WAKE_SEND → WAKE_WAIT] → IDLE → CMD → READ → GAP → IDLE.
- **INIT_WAIT**: counts `STARTUP_DELAY` cycles with `busy`=1. `start` is ignored.
- **IDLE**: `busy`=0. If `start`=1, capture `addr`, assert `flash_cs_n`=0 on the next edge and go to CMD.
- **CMD**: shifts out 32 bits: 0x03, then `addr[23:16]`, `addr[15:8]`, `addr[7:0]`.
- **READ**: shifts in `MEMORY_LENGTH*8` bits. Each byte assembles MSB first into an internal shift register, placed at byte index 0, 1, 2, ….
- **End of READ**:
  - The internal register is copied atomically to `data_out`.
  - `data_ready`=1 for one cycle.
  - `flash_cs_n` returns to 1 in that same cycle.
- **GAP**: holds `flash_cs_n` high for `2*CLK_DIV` cycles, then returns to IDLE.
- `data_out` holds its value between completions. Partial data is never visible.
- SPI mode 0:
  - `flash_mosi` changes only while `flash_clk` is low.
  - `flash_miso` is sampled in the `clk` cycle where `flash_clk` rises.
  - `flash_clk` is 0 whenever `flash_cs_n`=1.
- `flash_mosi` is 0 outside CMD.
- Bit and byte counters are sized by `$clog2`. The total bit count is N = 32 + 8*`MEMORY_LENGTH`.

## Timing
- Reset values:
  - `flash_cs_n`=1, `flash_clk`=0, `flash_mosi`=0.
  - `busy`=1, `data_ready`=0, `data_out`=0.
  - State = INIT_WAIT.
- If `start` is sampled at edge k in IDLE:
  - `flash_cs_n`=0 from k+1.
  - The first `flash_clk` rise is at k+1+`CLK_DIV`.
  - `data_ready` and `flash_cs_n` rise at k+1+2·N·`CLK_DIV`.
  - `busy` falls 2·`CLK_DIV` cycles later.
- Defaults (M=4, `CLK_DIV`=2): 256 cycles from acceptance to `data_ready`.
- `start` while `busy`: ignored, not queued.
- Reset during a transfer: all outputs return to their reset values at that edge, `flash_cs_n` goes high immediately, and INIT_WAIT restarts.
- `start` held high: a new read begins on the first IDLE cycle after GAP.

## Configuration
- `FLASH_READER_WAKE_EN` defined: after INIT_WAIT, and once per reset only, the block sends a Release-Power-Down command.
  - WAKE_SEND: 0xAB, 8 bits, CS low.
  - WAKE_WAIT: CS high for `WAKE_DELAY_CYCLES` (81 = 3 µs tRES1).
  - Then IDLE. `busy` stays 1 throughout.
- Undefined: INIT_WAIT goes directly to IDLE. The WAKE states are absent.

## Structure
- Package `flash_pkg`:
  - state enum
  - opcodes `OP_READ`=8'h03, `OP_WAKE`=8'hAB
  - `WAKE_DELAY_CYCLES`=81
- Sub-module `flash_spi_phy`:
  - SCK divider and mode-0 edge strobes.
  - One-bit shift in/out per SCK period, with a `bit_done` strobe.
  - The FSM in `flash_reader` counts bits and handles CS.

## Test plan
- Model memory at 0x000000 = 48 65 6C 6C, `start`=1 for one cycle with `addr`=0 → MOSI shows 03 00 00 00; `data_out`=32'h6C6C6548; one `data_ready` pulse 256 cycles after acceptance; `busy` low 4 cycles later.
- `addr`=24'h012345 → MOSI bytes 03 01 23 45. SCK period is 4 `clk` cycles. `flash_clk` is 0 whenever CS is high.
- `start` pulsed during INIT_WAIT and mid-READ → no extra CS assertion. `data_out` changes only once.
- `rst_n`=0 at bit 40 of READ → next edge: `flash_cs_n`=1, `flash_clk`=0, `data_out`=0, `busy`=1; `STARTUP_DELAY` is re-counted.
- `start` held high continuously → back-to-back reads separated by ≥4 cycles of CS high. `data_ready` pulses once per read.
- `FLASH_READER_WAKE_EN` defined → after INIT_WAIT: 8 SCK with MOSI=0xAB, CS high for 81 cycles, then IDLE. After a later `start`: no second 0xAB.
